axi4lite_regfile: RTL and testbench
===================================

Name: axi4lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file; the synthesizable successor to the behavioural AXI4-Lite slave model.
- Generalised in data width, register count and per-register read-only mode.
- Adds byte-strobe writes, independent AW/W arrival, SLVERR decoding and hardware-side register outputs.
- Sits between an AXI4-Lite master, or the interconnect, and block control/status logic.

Parameters:
- N, 4: data bus width in bytes; WDATA/RDATA are 8*N bits; N is a power of 2.
- A, 12: address width.
- R, 16: number of registers; R is a power of 2 and R*N <= 2^A.
- RO_MASK, {R{1'b0}}: bit i=1 makes register i read-only; it reads ro_i word i and rejects writes.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWADDR  in  A  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  8*N  write data.
- WSTRB  in  N  byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  A  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  8*N  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read valid.
- RREADY  in  1  read ready.
- ro_i  in  R*8*N  hardware values for read-only registers; word i is ro_i[i*8N +: 8N].
- reg_o  out  R*8*N  current contents of the writable registers; read-only words are driven 0.
- wr_pulse_o  out  R  one-cycle strobe for register i, high in the cycle after a successful write to it.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - All registers, BVALID, RVALID, wr_pulse_o, aw_held and w_held clear to 0.
  - RDATA, BRESP and RRESP clear to 0.
  - AWREADY, WREADY and ARREADY are forced low while ARESETn is low.
  - Reset mid-transaction discards all held and pending state; no partial write occurs.
- Address decode:
  - Word index = addr[log2(N) +: log2(R)].
  - Address is in range when addr < R*N; the low log2(N) bits are ignored.
- Write channel:
  - AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID.
  - An AW handshake latches AWADDR and sets aw_held; a W handshake latches WDATA/WSTRB and sets w_held. They may complete in the same cycle or in either order, any gap apart.
  - Commit edge: the edge where both are held, or where the second handshake completes.
  - On commit, if the address is in range and the target is writable, each byte b with WSTRB[b]=1 is updated and BRESP=00.
  - On commit, if the address is out of range or the target is read-only, no change is made and BRESP=10 (SLVERR).
  - At the commit edge BVALID rises, aw_held and w_held clear, and wr_pulse_o[idx] is asserted for one cycle on a successful write only.
  - A successful write with WSTRB=0 still pulses wr_pulse_o and leaves data unchanged.
  - BVALID holds, with BRESP stable, until the BREADY handshake; no new AW/W is accepted while BVALID=1.
  - When BVALID=0, AW and W for the next transaction are accepted in the cycle after the B handshake.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA is captured from pre-edge contents: ro_i word if read-only, register if writable, 0 if out of range.
  - RRESP is 00 in range and 10 out of range; RVALID rises at that edge (1-cycle latency).
  - RVALID, RDATA and RRESP hold until the RREADY handshake.
  - Maximum read throughput is one transaction per 2 cycles.
- Simultaneous events:
  - A read capture and a write commit on the same edge to the same register returns the old value.
  - Read and write channels are fully independent.
- Output stability: all outputs except AWREADY, WREADY and ARREADY are registered.

Test Plan:
- Reset then AW+W same cycle: AWADDR=0x008, WDATA=0x12345678, WSTRB=1111 -> BVALID next cycle, BRESP=00, reg_o word2=0x12345678, wr_pulse_o=0x0004 for one cycle.
- W two cycles before AW: addr 0x008, WDATA=0xAABBCCDD, WSTRB=1011 -> word2=0xAA34CCDD, BRESP=00; AWREADY/WREADY low while BVALID held with BREADY=0 for 5 cycles.
- Read 0x008 with RREADY=0 for 3 cycles -> RVALID after 1 cycle, RDATA=0xAA34CCDD stable, RRESP=00, ARREADY=0 until the handshake.
- Out-of-range write to 0x040 (R=16, N=4) -> BRESP=10, no register change, no wr_pulse_o. Out-of-range read -> RDATA=0, RRESP=10.
- RO_MASK=0x0001, ro_i word0=0xCAFEF00D: write to 0x000 -> BRESP=10, reg unchanged. Read 0x000 -> 0xCAFEF00D, RRESP=00.
- Write commit and AR to word3 on the same edge, old=0, new=0x5 -> RDATA=0. A second read returns 0x5. ARESETn pulsed with only AW held -> no write occurs, all outputs 0, and the next full transaction completes normally.

Source files
------------

// File: rtl/axi4lite_regfile_if.sv
// axi4lite_regfile_if
//   AXI4-Lite bus bundle between a master (or interconnect) and the
//   axi4lite_regfile slave.
//   Parameters: N = data width in bytes, A = address width.
//   Signals: AW channel (AWADDR/AWPROT/AWVALID/AWREADY),
//            W channel  (WDATA/WSTRB/WVALID/WREADY),
//            B channel  (BRESP/BVALID/BREADY),
//            AR channel (ARADDR/ARPROT/ARVALID/ARREADY),
//            R channel  (RDATA/RRESP/RVALID/RREADY).
interface axi4lite_regfile_if #(
    parameter int N = 4,
    parameter int A = 12
);
    logic [A-1:0]   AWADDR;
    logic [2:0]     AWPROT;
    logic           AWVALID;
    logic           AWREADY;
    logic [8*N-1:0] WDATA;
    logic [N-1:0]   WSTRB;
    logic           WVALID;
    logic           WREADY;
    logic [1:0]     BRESP;
    logic           BVALID;
    logic           BREADY;
    logic [A-1:0]   ARADDR;
    logic [2:0]     ARPROT;
    logic           ARVALID;
    logic           ARREADY;
    logic [8*N-1:0] RDATA;
    logic [1:0]     RRESP;
    logic           RVALID;
    logic           RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi4lite_regfile.sv
// axi4lite_regfile
//   Parametrised AXI4-Lite slave register file with byte-strobe writes,
//   independent AW/W arrival, SLVERR for out-of-range or read-only targets,
//   and hardware-side register outputs.
//   Ports:
//     ACLK, ARESETn  clock and asynchronous active-low reset
//     s_axi          AXI4-Lite slave bus (axi4lite_regfile_if.slave)
//     ro_i           hardware values for read-only words (word i = ro_i[i*8N +: 8N])
//     reg_o          writable register contents; read-only words read as 0
//     wr_pulse_o     one-cycle strobe per register after a successful write
module axi4lite_regfile #(
    parameter int            N       = 4,
    parameter int            A       = 12,
    parameter int            R       = 16,
    parameter logic [R-1:0]  RO_MASK = '0
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi4lite_regfile_if.slave    s_axi,
    input  logic [R*8*N-1:0]     ro_i,
    output logic [R*8*N-1:0]     reg_o,
    output logic [R-1:0]         wr_pulse_o
);

    localparam int NB = 8 * N;
    localparam int LN = (N > 1) ? $clog2(N) : 0;
    localparam int LR = (R > 1) ? $clog2(R) : 1;
    localparam logic [A:0] LIMIT = (A+1)'(R * N);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    // register storage
    logic [NB-1:0] regs     [R];
    logic [NB-1:0] ro_words [R];

    // write channel state
    logic          aw_held;
    logic          w_held;
    logic [A-1:0]  aw_addr_q;
    logic [NB-1:0] w_data_q;
    logic [N-1:0]  w_strb_q;
    logic          bvalid_q;
    resp_e         bresp_q;

    // read channel state
    logic          rvalid_q;
    logic [NB-1:0] rdata_q;
    resp_e         rresp_q;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [A-1:0]  wr_addr;
    logic [NB-1:0] wr_data;
    logic [N-1:0]  wr_strb;
    logic [LR-1:0] wr_idx, rd_idx;
    logic          wr_inr, wr_ok, rd_inr;
    logic [NB-1:0] rd_word;

    logic          unused_prot;
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    function automatic logic in_range(input logic [A-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // ready signals; forced low while reset is asserted
    assign s_axi.AWREADY = ARESETn & ~aw_held & ~bvalid_q;
    assign s_axi.WREADY  = ARESETn & ~w_held  & ~bvalid_q;
    assign s_axi.ARREADY = ARESETn & ~rvalid_q;

    assign aw_hs = s_axi.AWVALID & s_axi.AWREADY;
    assign w_hs  = s_axi.WVALID  & s_axi.WREADY;
    assign ar_hs = s_axi.ARVALID & s_axi.ARREADY;

    assign s_axi.BVALID = bvalid_q;
    assign s_axi.BRESP  = bresp_q;
    assign s_axi.RVALID = rvalid_q;
    assign s_axi.RDATA  = rdata_q;
    assign s_axi.RRESP  = rresp_q;

    // The write commits on the edge where the second of AW/W lands, so the
    // effective address/data come from the holding register if already
    // captured, otherwise straight from the bus.
    always_comb begin
        wr_addr = aw_held ? aw_addr_q : s_axi.AWADDR;
        wr_data = w_held  ? w_data_q  : s_axi.WDATA;
        wr_strb = w_held  ? w_strb_q  : s_axi.WSTRB;
        commit  = (aw_held | aw_hs) & (w_held | w_hs);
        wr_idx  = wr_addr[LN +: LR];
        wr_inr  = in_range(wr_addr);
        wr_ok   = wr_inr & ~RO_MASK[wr_idx];
    end

    always_comb begin
        for (int unsigned i = 0; i < R; i++) begin
            ro_words[i] = ro_i[i*NB +: NB];
        end
    end

    always_comb begin
        rd_idx  = s_axi.ARADDR[LN +: LR];
        rd_inr  = in_range(s_axi.ARADDR);
        rd_word = '0;
        if (rd_inr) begin
            rd_word = RO_MASK[rd_idx] ? ro_words[rd_idx] : regs[rd_idx];
        end
    end

    always_comb begin
        reg_o = '0;
        for (int unsigned i = 0; i < R; i++) begin
            reg_o[i*NB +: NB] = RO_MASK[i] ? '0 : regs[i];
        end
    end

    // write address/data capture and response
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (bvalid_q && s_axi.BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    wr_pulse_o[wr_idx] <= 1'b1;
                end
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi.AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.WDATA;
                    w_strb_q <= s_axi.WSTRB;
                end
            end
        end
    end

    // register array, byte-strobed update
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < R; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int unsigned b = 0; b < N; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // read channel; captures pre-edge contents so a same-edge write is not seen
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_inr ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_regfile.sv
// tb_axi4lite_regfile
//   Self-checking bench for axi4lite_regfile (N=4, A=12, R=16, RO word 0).
//   A transaction-level model tracks register contents and channel state;
//   a compare process checks every DUT output against it on each negedge.
module tb_axi4lite_regfile;
    localparam int N  = 4;
    localparam int A  = 12;
    localparam int R  = 16;
    localparam int NB = 32;
    localparam logic [R-1:0] ROM = 16'h0001;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic [R*NB-1:0] ro_i;
    logic [R*NB-1:0] reg_o;
    logic [R-1:0]    wr_pulse_o;

    axi4lite_regfile_if #(.N(N), .A(A)) bus ();

    axi4lite_regfile #(.N(N), .A(A), .R(R), .RO_MASK(ROM)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .s_axi      (bus),
        .ro_i       (ro_i),
        .reg_o      (reg_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem [R];
    bit          m_haw, m_hw, m_bv, m_rv;
    logic [11:0] m_aa;
    logic [31:0] m_wd;
    logic [3:0]  m_ws;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic [15:0] m_pulse;

    function automatic bit inr(input logic [11:0] a);
        return int'(a) < R * N;
    endfunction

    function automatic int widx(input logic [11:0] a);
        return (int'(a) / N) % R;
    endfunction

    initial begin
        forever begin
            @(posedge ACLK or negedge ARESETn);
            if (!ARESETn) begin
                for (int k = 0; k < R; k++) mem[k] = '0;
                m_haw = 0; m_hw = 0; m_bv = 0; m_rv = 0;
                m_aa = '0; m_wd = '0; m_ws = '0;
                m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_pulse = '0;
            end else begin
                bit awh, wh, arh;
                logic [11:0] a;
                logic [31:0] d, m;
                logic [3:0] s;
                int k;
                awh = bus.AWVALID && !m_haw && !m_bv;
                wh  = bus.WVALID  && !m_hw  && !m_bv;
                arh = bus.ARVALID && !m_rv;
                m_pulse = '0;
                // read sees contents from before this edge
                if (arh) begin
                    m_rv = 1;
                    a = bus.ARADDR;
                    if (!inr(a)) begin
                        m_rdata = '0;
                        m_rresp = 2'b10;
                    end else begin
                        k = widx(a);
                        m_rdata = ROM[k] ? ro_i[k*NB +: NB] : mem[k];
                        m_rresp = 2'b00;
                    end
                end else if (m_rv && bus.RREADY) begin
                    m_rv = 0;
                end
                if (m_bv && bus.BREADY) m_bv = 0;
                if ((m_haw || awh) && (m_hw || wh)) begin
                    a = m_haw ? m_aa : bus.AWADDR;
                    d = m_hw ? m_wd : bus.WDATA;
                    s = m_hw ? m_ws : bus.WSTRB;
                    m_haw = 0; m_hw = 0; m_bv = 1;
                    if (inr(a) && !ROM[widx(a)]) begin
                        k = widx(a);
                        m = '0;
                        for (int b = 0; b < N; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
                        mem[k] = (mem[k] & ~m) | (d & m);
                        m_bresp = 2'b00;
                        m_pulse = 16'(1) << k;
                    end else begin
                        m_bresp = 2'b10;
                    end
                end else begin
                    if (awh) begin m_haw = 1; m_aa = bus.AWADDR; end
                    if (wh)  begin m_hw = 1; m_wd = bus.WDATA; m_ws = bus.WSTRB; end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            logic [R*NB-1:0] exp_reg;
            @(negedge ACLK);
            chk("awready", bus.AWREADY, ARESETn && !m_haw && !m_bv);
            chk("wready",  bus.WREADY,  ARESETn && !m_hw && !m_bv);
            chk("arready", bus.ARREADY, ARESETn && !m_rv);
            chk("bvalid",  bus.BVALID,  m_bv);
            if (m_bv) chk("bresp", bus.BRESP, m_bresp);
            chk("rvalid",  bus.RVALID,  m_rv);
            if (m_rv) begin
                chk("rdata", bus.RDATA, m_rdata);
                chk("rresp", bus.RRESP, m_rresp);
            end
            for (int k = 0; k < R; k++) exp_reg[k*NB +: NB] = ROM[k] ? 32'h0 : mem[k];
            chk("reg_o", reg_o, exp_reg);
            chk("wr_pulse", wr_pulse_o, m_pulse);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_aw(input logic [11:0] a, input int dly);
        repeat (dly) tick();
        bus.AWADDR = a;
        bus.AWVALID = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bit hs;
            hs = bus.AWREADY;
            tick();
            if (hs) begin
                bus.AWVALID = 1'b0;
                return;
            end
        end
        bus.AWVALID = 1'b0;
        tmo("aw_handshake");
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        repeat (dly) tick();
        bus.WDATA = d;
        bus.WSTRB = s;
        bus.WVALID = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bit hs;
            hs = bus.WREADY;
            tick();
            if (hs) begin
                bus.WVALID = 1'b0;
                return;
            end
        end
        bus.WVALID = 1'b0;
        tmo("w_handshake");
    endtask

    task automatic do_b(input int bdly, output logic [1:0] resp, output logic [15:0] pulse,
                        output bit rdy_seen);
        bit got;
        got = 0;
        rdy_seen = 0;
        resp = 2'bxx;
        pulse = 'x;
        for (int i = 0; i < 64; i++) begin
            if (bus.BVALID) begin got = 1; break; end
            tick();
        end
        if (!got) begin
            tmo("b_valid");
            return;
        end
        resp = bus.BRESP;
        pulse = wr_pulse_o;
        repeat (bdly) begin
            if (bus.AWREADY || bus.WREADY) rdy_seen = 1;
            tick();
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd,
                            output logic [1:0] resp, output logic [15:0] pulse,
                            output bit rdy_seen);
        fork
            do_aw(a, awd);
            do_w(d, s, wd);
        join
        do_b(bd, resp, pulse, rdy_seen);
    endtask

    task automatic do_read(input logic [11:0] a, input int dly, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit got, hs_done;
        got = 0;
        hs_done = 0;
        data = 'x;
        resp = 2'bxx;
        repeat (dly) tick();
        bus.ARADDR = a;
        bus.ARVALID = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bit hs;
            hs = bus.ARREADY;
            tick();
            if (hs) begin hs_done = 1; break; end
        end
        bus.ARVALID = 1'b0;
        if (!hs_done) begin
            tmo("ar_handshake");
            return;
        end
        for (int i = 0; i < 64; i++) begin
            if (bus.RVALID) begin got = 1; break; end
            tick();
        end
        if (!got) begin
            tmo("r_valid");
            return;
        end
        repeat (rdly) tick();
        data = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]  resp, rr;
        logic [15:0] pulse;
        logic [31:0] rd;
        bit          rdy;

        bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
        bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;
        for (int k = 0; k < R; k++) ro_i[k*NB +: NB] = $urandom;
        ro_i[0 +: NB] = 32'hCAFEF00D;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", bus.AWREADY, 1'b0);
        chk("rst_arready", bus.ARREADY, 1'b0);
        chk("rst_bvalid",  bus.BVALID, 1'b0);
        chk("rst_rvalid",  bus.RVALID, 1'b0);
        chk("rst_rdata",   bus.RDATA, 32'h0);
        chk("rst_bresp",   bus.BRESP, 2'b00);
        chk("rst_rresp",   bus.RRESP, 2'b00);
        chk("rst_reg_o",   reg_o, '0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        tick();

        // AW+W same cycle
        do_write(12'h008, 32'h12345678, 4'b1111, 0, 0, 0, resp, pulse, rdy);
        chk("t1_bresp", resp, 2'b00);
        chk("t1_pulse", pulse, 16'h0004);
        chk("t1_word2", reg_o[2*NB +: NB], 32'h12345678);

        // W two cycles before AW, BREADY held off 5 cycles
        do_write(12'h008, 32'hAABBCCDD, 4'b1011, 2, 0, 5, resp, pulse, rdy);
        chk("t2_bresp", resp, 2'b00);
        chk("t2_ready_while_b", rdy, 1'b0);
        chk("t2_word2", reg_o[2*NB +: NB], 32'hAA34CCDD);

        // read with RREADY held off
        do_read(12'h008, 0, 3, rd, rr);
        chk("t3_rdata", rd, 32'hAA34CCDD);
        chk("t3_rresp", rr, 2'b00);

        // out of range
        do_write(12'h040, 32'hFFFFFFFF, 4'b1111, 0, 1, 0, resp, pulse, rdy);
        chk("t4_bresp", resp, 2'b10);
        chk("t4_pulse", pulse, 16'h0000);
        do_read(12'h044, 0, 0, rd, rr);
        chk("t4_rdata", rd, 32'h0);
        chk("t4_rresp", rr, 2'b10);

        // read-only word 0
        do_write(12'h000, 32'h11111111, 4'b1111, 1, 0, 0, resp, pulse, rdy);
        chk("t5_bresp", resp, 2'b10);
        chk("t5_pulse", pulse, 16'h0000);
        do_read(12'h000, 0, 0, rd, rr);
        chk("t5_rdata", rd, 32'hCAFEF00D);
        chk("t5_rresp", rr, 2'b00);

        // write commit and read capture on the same edge
        fork
            do_write(12'h00C, 32'h5, 4'b1111, 0, 0, 0, resp, pulse, rdy);
            do_read(12'h00C, 0, 0, rd, rr);
        join
        chk("t6_old_value", rd, 32'h0);
        do_read(12'h00C, 0, 0, rd, rr);
        chk("t6_new_value", rd, 32'h5);

        // reset with only AW held
        do_aw(12'h010, 0);
        #2;
        ARESETn = 1'b0;
        tick();
        chk("t7_awready", bus.AWREADY, 1'b0);
        chk("t7_wready",  bus.WREADY, 1'b0);
        chk("t7_bvalid",  bus.BVALID, 1'b0);
        chk("t7_rvalid",  bus.RVALID, 1'b0);
        chk("t7_reg_o",   reg_o, '0);
        chk("t7_pulse",   wr_pulse_o, 16'h0000);
        ARESETn = 1'b1;
        tick();
        do_write(12'h010, 32'h77, 4'b1111, 0, 0, 0, resp, pulse, rdy);
        chk("t7_bresp", resp, 2'b00);
        chk("t7_pulse_after", pulse, 16'h0010);
        chk("t7_word4", reg_o[4*NB +: NB], 32'h00000077);

        // randomized independent write and read traffic
        fork
            begin
                logic [1:0]  wresp;
                logic [15:0] wpulse;
                bit          wrdy;
                for (int t = 0; t < 200; t++) begin
                    do_write(12'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                             wresp, wpulse, wrdy);
                end
            end
            begin
                logic [31:0] rdat;
                logic [1:0]  rrsp;
                for (int t = 0; t < 200; t++) begin
                    do_read(12'($urandom_range(0, 127)), $urandom_range(0, 3),
                            $urandom_range(0, 3), rdat, rrsp);
                end
            end
        join
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
